system_worker_cpu_debug_mem_arbiter: RTL

Arbitrates the CPU debug memory (OCI on-chip debug RAM) between two requesters.
- Avalon debug_mem slave port: CPU and system side.
- JTAG debug command path: sysclk-side take_action ocimem pulses, with an auto-incrementing address register.
- Sits between the debug slave sysclk logic and a single-port registered RAM. Round-robin arbitration, one access in flight.

---
 rtl/system_worker_cpu_debug_mem_arbiter_if.sv | 24 ++
 rtl/system_worker_cpu_debug_mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/system_worker_cpu_debug_mem_arbiter_if.sv
// Avalon-MM debug_mem slave bundle shared by the CPU/system side and the
// debug RAM arbiter.
interface system_worker_cpu_debug_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avl_address;
    logic                avl_read;
    logic                avl_write;
    logic [DATA_W-1:0]   avl_writedata;
    logic [DATA_W/8-1:0] avl_byteenable;
    logic                avl_waitrequest;
    logic [DATA_W-1:0]   avl_readdata;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        input  avl_waitrequest, avl_readdata
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        output avl_waitrequest, avl_readdata
    );
endinterface

// File: rtl/system_worker_cpu_debug_mem_arbiter.sv
// Round-robin arbiter giving the Avalon debug_mem port and the JTAG command
// path alternating access to a single-port registered debug RAM.
module system_worker_cpu_debug_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    system_worker_cpu_debug_mem_arbiter_if.slave avl,
    input  logic                jtag_load_addr,
    input  logic [ADDR_W-1:0]   jtag_addr,
    input  logic                jtag_rd,
    input  logic                jtag_wr,
    input  logic [DATA_W-1:0]   jtag_wdata,
    output logic                jtag_busy,
    output logic                jtag_done,
    output logic [DATA_W-1:0]   jtag_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W/8-1:0] ram_byteen,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, DONE} state_t;
    typedef enum logic {SRC_AVL, SRC_JTAG} src_t;

    state_t              state;
    src_t                last_grant;
    src_t                owner;
    logic                cur_rd;
    logic                pending;
    logic                pend_wr;
    logic [DATA_W-1:0]   pend_wdata;
    logic [ADDR_W-1:0]   jtag_addr_reg;

    logic avl_req;
    logic jtag_cmd;
    logic grant_jtag;

    assign avl_req    = avl.avl_read | avl.avl_write;
    assign jtag_cmd   = jtag_rd | jtag_wr;
    // Under contention the requester that was not served last wins.
    assign grant_jtag = pending & (~avl_req | (last_grant == SRC_AVL));

    // NOTE: every register below uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            last_grant          <= SRC_JTAG;
            owner               <= SRC_AVL;
            cur_rd              <= 1'b0;
            pending             <= 1'b0;
            pend_wr             <= 1'b0;
            pend_wdata          <= '0;
            jtag_addr_reg       <= '0;
            avl.avl_waitrequest <= 1'b1;
            avl.avl_readdata    <= '0;
            jtag_busy           <= 1'b0;
            jtag_done           <= 1'b0;
            jtag_rdata          <= '0;
            ram_addr            <= '0;
            ram_wren            <= 1'b0;
            ram_byteen          <= '0;
            ram_wdata           <= '0;
        end else begin
            avl.avl_waitrequest <= 1'b1;
            jtag_done           <= 1'b0;

            // Closing edge of a JTAG completion: release busy, step the address.
            if (jtag_done) begin
                jtag_busy     <= 1'b0;
                jtag_addr_reg <= jtag_addr_reg + ADDR_W'(1);
            end

            if (!jtag_busy) begin
                if (jtag_load_addr) jtag_addr_reg <= jtag_addr;
                if (jtag_cmd) begin
                    pending    <= 1'b1;
                    pend_wr    <= jtag_wr;
                    pend_wdata <= jtag_wdata;
                    jtag_busy  <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (avl_req || pending) begin
                        state <= ACCESS;
                        if (grant_jtag) begin
                            owner      <= SRC_JTAG;
                            last_grant <= SRC_JTAG;
                            pending    <= 1'b0;
                            cur_rd     <= ~pend_wr;
                            ram_addr   <= jtag_addr_reg;
                            ram_wdata  <= pend_wdata;
                            ram_byteen <= '1;
                            ram_wren   <= pend_wr;
                            jtag_done  <= pend_wr;
                        end else begin
                            owner               <= SRC_AVL;
                            last_grant          <= SRC_AVL;
                            cur_rd              <= ~avl.avl_write;
                            ram_addr            <= avl.avl_address;
                            ram_wdata           <= avl.avl_writedata;
                            ram_byteen          <= avl.avl_write ? avl.avl_byteenable : '1;
                            ram_wren            <= avl.avl_write;
                            avl.avl_waitrequest <= ~avl.avl_write;
                        end
                    end
                end
                ACCESS: begin
                    ram_wren <= 1'b0;
                    state    <= cur_rd ? RDATA : IDLE;
                end
                RDATA: begin
                    if (owner == SRC_JTAG) begin
                        jtag_rdata <= ram_rdata;
                        jtag_done  <= 1'b1;
                    end else begin
                        avl.avl_readdata    <= ram_rdata;
                        avl.avl_waitrequest <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
